c_decompress_stage: RTL and testbench
=====================================

# c_decompress_stage

Registered RV32C expansion stage between the misaligned-instruction realigner and the decoder. Accepts one realigned instruction per cycle with its PC, expands 16-bit compressed encodings to their 32-bit equivalents, and passes 32-bit encodings through unchanged. Output uses a valid/ready handshake backed by a 2-entry skid buffer, so decoder stalls never drop or reorder instructions. A branch redirect flushes all held entries.

## Interface
- ENABLE_FD, 0: if 1, C.FLD/C.FSD/C.FLDSP/C.FSDSP/C.FLW/C.FSW/C.FLWSP/C.FSWSP expand; if 0, they flag illegal.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- sel_for_branch  in  1  branch-taken redirect; flushes the stage.
- in_valid_i  in  1  pc_i/inst_i hold a realigned instruction.
- in_ready_o  out  1  stage can accept this cycle.
- pc_i  in  32  PC of the instruction.
- inst_i  in  32  instruction; for compressed, [15:0] is valid and [31:16] is don't-care.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  decoder accepts the output entry.
- pc_o  out  32  PC of the output entry.
- inst_o  out  32  expanded or passed-through instruction.
- npc_o  out  32  pc_o + 2 if compressed, else pc_o + 4 (mod 2^32).
- is_compressed_o  out  1  source was 16-bit.
- illegal_o  out  1  illegal or reserved compressed encoding.

## Operation
- Compressed when inst_i[1:0] != 2'b11.
- Expansion follows the RV32C expansion table of the RISC-V Unprivileged ISA, quadrants 0–2. RV64/RV128-only encodings are illegal. Hint encodings expand normally.
- Illegal cases:
  - 16'h0000.
  - C.ADDI4SPN with nzuimm=0.
  - C.LUI with rd=2 or nzimm=0.
  - C.ADDI16SP with nzimm=0.
  - C.JR with rs1=0.
  - Reserved quadrant-1 funct6 100111 with funct2 bit set.
  - F/D forms when ENABLE_FD=0.
- On illegal: inst_o = {16'h0, inst_i[15:0]}, illegal_o=1, is_compressed_o=1.
- 32-bit input: inst_o = inst_i, is_compressed_o=0, illegal_o=0.
- Storage is an output register (OUT) plus a skid register (SKID), each with a valid bit. The entry holds pc, inst, npc, is_compressed and illegal.
- Transfer in: in_valid_i && in_ready_o. Transfer out: out_valid_o && out_ready_i.
- Transfer in with OUT empty, or with OUT draining the same cycle: the entry is written to OUT.
- Transfer in with OUT held: the entry is written to SKID.
- OUT drains and SKID is valid: SKID moves to OUT and SKID clears.
- in_ready_o = !SKID.valid, driven from a register with no combinational path from out_ready_i.

## Timing
- Latency: 1 cycle from an in-transfer to out_valid_o when no stall is pending.
- Throughput: 1 instruction/cycle.
- Reset (async assert, released synchronously by the surrounding design):
  - OUT.valid = SKID.valid = 0.
  - pc_o, inst_o, npc_o = 0.
  - is_compressed_o, illegal_o = 0.
  - in_ready_o = 1 during and after reset.
- Flush: sel_for_branch high at a rising edge clears OUT.valid and SKID.valid at that edge.
  - The same-cycle in-transfer is discarded.
  - The same-cycle out-transfer is still considered taken by the decoder.
  - Data registers keep their values; only valid bits clear.
- Flush and reset are both level-sensitive every cycle they are asserted. A flush held for N cycles discards N cycles of input.
- Output stability: while out_valid_o && !out_ready_i, every output holds stable.
- Both full: in_ready_o = 0 and in_valid_i is ignored. The upstream realigner holds stall_pc from in_ready_o.
- Simultaneous in and out transfer with SKID empty: OUT is replaced and out_valid_o stays 1.
- pc arithmetic is 32-bit with wrap-around: pc 32'hFFFF_FFFE, compressed → npc_o = 0.

## Structure
- Package c_ext_pkg holds:
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, LOAD_FP, STORE_FP).
  - Quadrant/funct3 constants.
  - The packed struct for an entry: pc, inst, npc, is_c, illegal.
- Sub-module c_expander (purely combinational: inst16 → inst32, illegal) holds the decode case.
- c_decompress_stage holds the skid/handshake registers and npc computation.

## Test plan
- c.addi x10,1: inst_i 32'h0000_0505, pc_i 32'h100 → next cycle inst_o 32'h0015_0513, npc_o 32'h102, is_compressed_o=1.
- c.mv x10,x11 (16'h852E) → inst_o 32'h00B0_0533. c.nop (16'h0001) → 32'h0000_0013.
- Illegal 16'h0000 → illegal_o=1, inst_o 32'h0. 32-bit 32'h0000_0013 at pc 32'h200 → passthrough, npc_o 32'h204, is_compressed_o=0.
- Backpressure: three back-to-back inputs with out_ready_i=0 for 2 cycles → in_ready_o=0 after the second input, third input held upstream, outputs appear in order with no loss.
- Flush: OUT and SKID both valid, sel_for_branch pulsed 1 cycle with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, flushed-cycle input never appears.
- Reset mid-stall, plus pc 32'hFFFF_FFFE compressed → all valids 0 immediately on reset; after release, npc_o wraps to 32'h0.

Source files
------------

// File: rtl/c_ext_pkg.sv
// Shared constants and the pipeline entry type for the RV32C expansion stage.
package c_ext_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] LOAD_FP  = 7'b0000111;
  localparam logic [6:0] STORE_FP = 7'b0100111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        is_c;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/c_expander.sv
// Combinational RV32C expander: 16-bit compressed encoding to its 32-bit equivalent.
module c_expander
  import c_ext_pkg::*;
#(
  parameter int ENABLE_FD = 0
) (
  input  logic [15:0] inst16_i,
  output logic [31:0] inst32_o,
  output logic        illegal_o
);

  logic [2:0]  f3;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic        i12, fd_off;
  logic [31:0] exp_s;
  logic        ill_s;

  assign f3     = inst16_i[15:13];
  assign rd     = inst16_i[11:7];
  assign rs2    = inst16_i[6:2];
  assign rdp    = {2'b01, inst16_i[4:2]};
  assign rs1p   = {2'b01, inst16_i[9:7]};
  assign i12    = inst16_i[12];
  assign fd_off = (ENABLE_FD == 0);

  // Decode table for quadrants 0..2; quadrant 3 never reaches the output.
  always_comb begin
    exp_s = 32'h0000_0000;
    ill_s = 1'b0;
    case (inst16_i[1:0])
      Q0: begin
        case (f3)
          3'b000: begin
            exp_s = {2'b00, inst16_i[10:7], inst16_i[12:11], inst16_i[5], inst16_i[6], 2'b00,
                     5'd2, 3'b000, rdp, OP_IMM};
            ill_s = (inst16_i[12:5] == 8'h00);
          end
          3'b001: begin
            exp_s = {4'b0000, inst16_i[6:5], inst16_i[12:10], 3'b000, rs1p, F3_D, rdp, LOAD_FP};
            ill_s = fd_off;
          end
          3'b010: exp_s = {5'b00000, inst16_i[5], inst16_i[12:10], inst16_i[6], 2'b00, rs1p, F3_W, rdp, LOAD};
          3'b011: begin
            exp_s = {5'b00000, inst16_i[5], inst16_i[12:10], inst16_i[6], 2'b00, rs1p, F3_W, rdp, LOAD_FP};
            ill_s = fd_off;
          end
          3'b101: begin
            exp_s = {4'b0000, inst16_i[6:5], inst16_i[12], rdp, rs1p, F3_D, inst16_i[11:10], 3'b000, STORE_FP};
            ill_s = fd_off;
          end
          3'b110: exp_s = {5'b00000, inst16_i[5], inst16_i[12], rdp, rs1p, F3_W, inst16_i[11:10], inst16_i[6], 2'b00, STORE};
          3'b111: begin
            exp_s = {5'b00000, inst16_i[5], inst16_i[12], rdp, rs1p, F3_W, inst16_i[11:10], inst16_i[6], 2'b00, STORE_FP};
            ill_s = fd_off;
          end
          default: ill_s = 1'b1;
        endcase
      end
      Q1: begin
        case (f3)
          3'b000: exp_s = {{7{i12}}, inst16_i[6:2], rd, 3'b000, rd, OP_IMM};
          3'b001: exp_s = {i12, inst16_i[8], inst16_i[10:9], inst16_i[6], inst16_i[7], inst16_i[2], inst16_i[11],
                           inst16_i[5:3], i12, {8{i12}}, 5'd1, JAL};
          3'b010: exp_s = {{7{i12}}, inst16_i[6:2], 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            ill_s = ({i12, inst16_i[6:2]} == 6'd0);
            if (rd == 5'd2) begin
              exp_s = {{3{i12}}, inst16_i[4:3], inst16_i[5], inst16_i[2], inst16_i[6], 4'b0000,
                       5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin
              exp_s = {{15{i12}}, inst16_i[6:2], rd, LUI};
            end
          end
          3'b100: begin
            case (inst16_i[11:10])
              2'b00: begin
                exp_s = {7'b0000000, inst16_i[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                ill_s = i12;
              end
              2'b01: begin
                exp_s = {7'b0100000, inst16_i[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                ill_s = i12;
              end
              2'b10: exp_s = {{7{i12}}, inst16_i[6:2], rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                // With bit 12 set these are RV64 word ops or reserved.
                ill_s = i12;
                case (inst16_i[6:5])
                  2'b00:   exp_s = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP};
                  2'b01:   exp_s = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP};
                  2'b10:   exp_s = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP};
                  default: exp_s = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP};
                endcase
              end
            endcase
          end
          3'b101: exp_s = {i12, inst16_i[8], inst16_i[10:9], inst16_i[6], inst16_i[7], inst16_i[2], inst16_i[11],
                           inst16_i[5:3], i12, {8{i12}}, 5'd0, JAL};
          3'b110: exp_s = {{4{i12}}, inst16_i[6:5], inst16_i[2], 5'd0, rs1p, F3_BEQ,
                           inst16_i[11:10], inst16_i[4:3], i12, BRANCH};
          default: exp_s = {{4{i12}}, inst16_i[6:5], inst16_i[2], 5'd0, rs1p, F3_BNE,
                            inst16_i[11:10], inst16_i[4:3], i12, BRANCH};
        endcase
      end
      Q2: begin
        case (f3)
          3'b000: begin
            exp_s = {7'b0000000, inst16_i[6:2], rd, 3'b001, rd, OP_IMM};
            ill_s = i12;
          end
          3'b001: begin
            exp_s = {3'b000, inst16_i[4:2], inst16_i[12], inst16_i[6:5], 3'b000, 5'd2, F3_D, rd, LOAD_FP};
            ill_s = fd_off;
          end
          3'b010: exp_s = {4'b0000, inst16_i[3:2], inst16_i[12], inst16_i[6:4], 2'b00, 5'd2, F3_W, rd, LOAD};
          3'b011: begin
            exp_s = {4'b0000, inst16_i[3:2], inst16_i[12], inst16_i[6:4], 2'b00, 5'd2, F3_W, rd, LOAD_FP};
            ill_s = fd_off;
          end
          3'b100: begin
            if (!i12) begin
              if (rs2 == 5'd0) begin
                exp_s = {12'h000, rd, 3'b000, 5'd0, JALR};
                ill_s = (rd == 5'd0);
              end else begin
                exp_s = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP};
              end
            end else if (rs2 == 5'd0) begin
              if (rd == 5'd0) begin
                exp_s = {12'h001, 5'd0, 3'b000, 5'd0, SYSTEM};
              end else begin
                exp_s = {12'h000, rd, 3'b000, 5'd1, JALR};
              end
            end else begin
              exp_s = {7'b0000000, rs2, rd, 3'b000, rd, OP};
            end
          end
          3'b101: begin
            exp_s = {3'b000, inst16_i[9:7], inst16_i[12], rs2, 5'd2, F3_D, inst16_i[11:10], 3'b000, STORE_FP};
            ill_s = fd_off;
          end
          3'b110: exp_s = {4'b0000, inst16_i[8:7], inst16_i[12], rs2, 5'd2, F3_W, inst16_i[11:9], 2'b00, STORE};
          default: begin
            exp_s = {4'b0000, inst16_i[8:7], inst16_i[12], rs2, 5'd2, F3_W, inst16_i[11:9], 2'b00, STORE_FP};
            ill_s = fd_off;
          end
        endcase
      end
      default: begin
        exp_s = 32'h0000_0000;
        ill_s = 1'b0;
      end
    endcase
  end

  assign illegal_o = ill_s;
  assign inst32_o  = ill_s ? {16'h0000, inst16_i} : exp_s;

endmodule

// File: rtl/c_decompress_stage.sv
// Registered RV32C expansion stage with an output register and one skid entry.
module c_decompress_stage
  import c_ext_pkg::*;
#(
  parameter int ENABLE_FD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_for_branch,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] npc_o,
  output logic        is_compressed_o,
  output logic        illegal_o
);

  entry_t      out_q, out_d, skid_q, skid_d, new_s;
  logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic        in_ready_q;
  logic        is_c_s, exp_ill_s, in_fire_s, out_fire_s;
  logic [31:0] exp_inst_s;

  c_expander #(.ENABLE_FD(ENABLE_FD)) u_expander (
    .inst16_i  (inst_i[15:0]),
    .inst32_o  (exp_inst_s),
    .illegal_o (exp_ill_s)
  );

  assign is_c_s         = (inst_i[1:0] != 2'b11);
  assign new_s.pc       = pc_i;
  assign new_s.inst     = is_c_s ? exp_inst_s : inst_i;
  assign new_s.npc      = pc_i + (is_c_s ? 32'd2 : 32'd4);
  assign new_s.is_c     = is_c_s;
  assign new_s.illegal  = is_c_s & exp_ill_s;

  assign in_fire_s  = in_valid_i & in_ready_q;
  assign out_fire_s = out_valid_q & out_ready_i;

  // Next-state for OUT/SKID; a flush clears valids only, data is left as is.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (sel_for_branch) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire_s || !out_valid_q) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire_s) begin
        out_d       = new_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_d       = new_s;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers; ready is registered so out_ready_i never reaches in_ready_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign pc_o            = out_q.pc;
  assign inst_o          = out_q.inst;
  assign npc_o           = out_q.npc;
  assign is_compressed_o = out_q.is_c;
  assign illegal_o       = out_q.illegal;

endmodule

// File: tb/tb_c_decompress_stage.sv
// Directed scoreboard bench for c_decompress_stage: expansion table, backpressure, flush, reset.
module tb_c_decompress_stage;

  logic        clk;
  logic        reset;
  logic        sel_for_branch;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] npc_o;
  logic        is_compressed_o;
  logic        illegal_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        is_c;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] exp_inst;
    logic        is_c;
    logic        ill;
  } vec_t;

  exp_t sb[$];
  exp_t pend;
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  c_decompress_stage #(.ENABLE_FD(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .sel_for_branch  (sel_for_branch),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .pc_i            (pc_i),
    .inst_i          (inst_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .npc_o           (npc_o),
    .is_compressed_o (is_compressed_o),
    .illegal_o       (illegal_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exp_inst,
                       input logic is_c, input logic ill);
    in_valid_i = 1'b1;
    pc_i       = pc;
    inst_i     = inst;
    pend.pc    = pc;
    pend.inst  = exp_inst;
    pend.npc   = pc + (is_c ? 32'd2 : 32'd4);
    pend.is_c  = is_c;
    pend.ill   = ill;
  endtask

  // Called at the falling edge: score this cycle's handshakes, then advance one clock.
  task automatic cycle();
    exp_t e;
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", pc_o, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("inst_o", inst_o, e.inst);
        chk("npc_o", npc_o, e.npc);
        chk("is_compressed_o", {31'd0, is_compressed_o}, {31'd0, e.is_c});
        chk("illegal_o", {31'd0, illegal_o}, {31'd0, e.ill});
      end
    end
    if (sel_for_branch) begin
      sb.delete();
    end else if (in_valid_i && in_ready_o) begin
      sb.push_back(pend);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 20 && (sb.size() > 0 || out_valid_o); k++) cycle();
    chk("drain_sb_empty", sb.size(), 32'd0);
    chk("drain_out_valid", {31'd0, out_valid_o}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    sel_for_branch = 1'b0;
    in_valid_i     = 1'b0;
    out_ready_i    = 1'b0;
    pc_i           = 32'h0;
    inst_i         = 32'h0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst_o", inst_o, 32'h0);
    chk("rst_npc_o", npc_o, 32'h0);
    chk("rst_flags", {30'd0, is_compressed_o, illegal_o}, 32'd0);
    reset = 1'b0;

    // First transfer: one-cycle latency.
    out_ready_i = 1'b1;
    drive(32'h100, 32'h0000_0505, 32'h0015_0513, 1'b1, 1'b0);
    cycle();
    chk("lat_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("lat_inst_o", inst_o, 32'h0015_0513);
    chk("lat_npc_o", npc_o, 32'h102);
    chk("lat_is_c", {31'd0, is_compressed_o}, 32'd1);

    vecs.push_back('{32'hDEAD_852E, 32'h00B0_0533, 1'b1, 1'b0}); // c.mv x10,x11
    vecs.push_back('{32'hBEEF_0001, 32'h0000_0013, 1'b1, 1'b0}); // c.nop
    vecs.push_back('{32'h1234_0000, 32'h0000_0000, 1'b1, 1'b1}); // all-zero illegal
    vecs.push_back('{32'h0000_0013, 32'h0000_0013, 1'b0, 1'b0}); // 32-bit addi
    vecs.push_back('{32'h0000_40C0, 32'h0044_A403, 1'b1, 1'b0}); // c.lw x8,4(x9)
    vecs.push_back('{32'h0000_52FD, 32'hFFF0_0293, 1'b1, 1'b0}); // c.li x5,-1
    vecs.push_back('{32'h0000_6101, 32'h0000_6101, 1'b1, 1'b1}); // c.addi16sp imm 0
    vecs.push_back('{32'h0000_8002, 32'h0000_8002, 1'b1, 1'b1}); // c.jr x0
    vecs.push_back('{32'h0000_6000, 32'h0000_6000, 1'b1, 1'b1}); // c.flw, FD disabled
    vecs.push_back('{32'h0000_9C41, 32'h0000_9C41, 1'b1, 1'b1}); // reserved funct6 100111
    vecs.push_back('{32'h0000_952E, 32'h00B5_0533, 1'b1, 1'b0}); // c.add x10,x11
    vecs.push_back('{32'h0000_C001, 32'h0004_0063, 1'b1, 1'b0}); // c.beqz x8,0
    vecs.push_back('{32'h0000_8C05, 32'h4094_0433, 1'b1, 1'b0}); // c.sub x8,x9
    vecs.push_back('{32'h0000_0040, 32'h0041_0413, 1'b1, 1'b0}); // c.addi4spn x8,4
    vecs.push_back('{32'h0000_C42A, 32'h00A1_2423, 1'b1, 1'b0}); // c.swsp x10,8
    for (int i = 0; i < vecs.size(); i++) begin
      drive(32'h200 + 32'(i * 4), vecs[i].inst, vecs[i].exp_inst, vecs[i].is_c, vecs[i].ill);
      cycle();
    end
    drain();

    // Backpressure: fill OUT and SKID, hold a third input upstream.
    out_ready_i = 1'b0;
    drive(32'h300, 32'h0000_0001, 32'h0000_0013, 1'b1, 1'b0);
    cycle();
    drive(32'h302, 32'h0000_852E, 32'h00B0_0533, 1'b1, 1'b0);
    cycle();
    chk("bp_in_ready_full", {31'd0, in_ready_o}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
    drive(32'h304, 32'h0000_0505, 32'h0015_0513, 1'b1, 1'b0);
    cycle();
    chk("bp_stable_pc", pc_o, 32'h300);
    chk("bp_stable_inst", inst_o, 32'h0000_0013);
    chk("bp_in_ready_held", {31'd0, in_ready_o}, 32'd0);
    out_ready_i = 1'b1;
    cycle();
    chk("bp_skid_to_out", pc_o, 32'h302);
    chk("bp_in_ready_back", {31'd0, in_ready_o}, 32'd1);
    cycle();
    drain();

    // Flush with both entries held and input offered.
    out_ready_i = 1'b0;
    drive(32'h400, 32'h0000_0001, 32'h0000_0013, 1'b1, 1'b0);
    cycle();
    drive(32'h402, 32'h0000_0505, 32'h0015_0513, 1'b1, 1'b0);
    cycle();
    chk("fl_full", {31'd0, in_ready_o}, 32'd0);
    drive(32'h404, 32'h0000_852E, 32'h00B0_0533, 1'b1, 1'b0);
    sel_for_branch = 1'b1;
    cycle();
    sel_for_branch = 1'b0;
    in_valid_i     = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready_o}, 32'd1);
    // Flush with room available: the accepted input is still discarded.
    drive(32'h500, 32'h0000_0001, 32'h0000_0013, 1'b1, 1'b0);
    sel_for_branch = 1'b1;
    cycle();
    sel_for_branch = 1'b0;
    chk("fl2_out_valid", {31'd0, out_valid_o}, 32'd0);
    drain();

    // Asynchronous reset in the middle of a stall.
    out_ready_i = 1'b0;
    drive(32'h600, 32'h0000_0001, 32'h0000_0013, 1'b1, 1'b0);
    cycle();
    drive(32'h602, 32'h0000_0505, 32'h0015_0513, 1'b1, 1'b0);
    cycle();
    in_valid_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst2_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst2_pc_o", pc_o, 32'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready_i = 1'b1;
    drive(32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0013, 1'b1, 1'b0);
    cycle();
    chk("wrap_npc_o", npc_o, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
